// File: rtl/mult_div_unit_if.sv
// Start/operand/result bundle between the multicycle control FSM and the MULT/DIV unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             MDcontrol;
    logic             MDop;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             done;
    logic             busy;
    logic             Div0;

    modport master (output MDcontrol, MDop, A, B, input HI, LO, done, busy, Div0);
    modport slave  (input MDcontrol, MDop, A, B, output HI, LO, done, busy, Div0);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV: shift-add / restoring division on operand magnitudes,
// with the sign fix-up applied in a single final cycle before HI/LO are written.
//
// state  | meaning
// S_IDLE | waiting for a start strobe; operands latched on MDcontrol
// S_CALC | WIDTH iterations of shift-add (MULT) or restoring divide (DIV)
// S_FIX  | sign correction, HI/LO write (or Div0 report), done pulse
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    mult_div_unit_if.slave md
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a_mag;
    logic [WIDTH-1:0]   r_b_mag;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_op;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div0;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quot_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // MULT: add multiplicand to the upper half when the multiplier LSB is set.
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b_mag[0] ? {1'b0, r_a_mag} : '0);

    // DIV: the dividend streams into the remainder MSB-first from r_a_mag.
    assign w_rem_sh    = {r_acc[2*WIDTH-2:WIDTH], r_a_mag[WIDTH-1]};
    assign w_trial     = {1'b0, w_rem_sh} - {1'b0, r_b_mag};
    assign w_rem_next  = w_trial[WIDTH] ? w_rem_sh : w_trial[WIDTH-1:0];
    assign w_quot_next = {r_acc[WIDTH-2:0], ~w_trial[WIDTH]};

    assign w_prod = r_sign_q ? -r_acc : r_acc;
    assign w_rem  = r_acc[2*WIDTH-1:WIDTH];
    assign w_quot = r_acc[WIDTH-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (md.MDcontrol)
                        w_state_next = (md.MDop && (md.B == '0)) ? S_FIX : S_CALC;
            S_CALC: if (r_cnt == CW'(1)) w_state_next = S_FIX;
            S_FIX:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_a_mag  <= '0;
            r_b_mag  <= '0;
            r_acc    <= '0;
            r_op     <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_zero   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (md.MDcontrol) begin
                        r_a_mag  <= md.A[WIDTH-1] ? -md.A : md.A;
                        r_b_mag  <= md.B[WIDTH-1] ? -md.B : md.B;
                        r_sign_q <= md.A[WIDTH-1] ^ md.B[WIDTH-1];
                        r_sign_r <= md.A[WIDTH-1];
                        r_op     <= md.MDop;
                        r_zero   <= md.MDop && (md.B == '0);
                        r_acc    <= '0;
                        r_cnt    <= CW'(WIDTH);
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (!r_op) begin
                        r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
                        r_b_mag <= r_b_mag >> 1;
                    end else begin
                        r_acc   <= {w_rem_next, w_quot_next};
                        r_a_mag <= r_a_mag << 1;
                    end
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_zero) begin
                        r_div0 <= 1'b1;
                    end else if (!r_op) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else begin
                        r_lo <= r_sign_q ? -w_quot : w_quot;
                        r_hi <= r_sign_r ? -w_rem : w_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md.HI   = r_hi;
    assign md.LO   = r_lo;
    assign md.done = r_done;
    assign md.Div0 = r_div0;
    assign md.busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/Div0 come from a 64-bit signed model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mult_div_unit_if #(.WIDTH(W)) md();
    mult_div_unit #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .md(md));

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           total = 0;
    int           bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sd, p, q, r;
        sa = longint'($signed(a));
        sd = longint'($signed(b));
        if (!op) begin
            p = sa * sd;
            e.hi = p[63:32]; e.lo = p[31:0]; e.div0 = 1'b0;
        end else if (b == '0) begin
            e.hi = m_hi; e.lo = m_lo; e.div0 = 1'b1;
        end else begin
            q = sa / sd;
            r = sa % sd;
            e.hi = r[31:0]; e.lo = q[31:0]; e.div0 = 1'b0;
        end
        m_hi = e.hi;
        m_lo = e.lo;
        sbq.push_back(e);
    endtask

    task automatic start(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        md.MDop = op; md.A = a; md.B = b; md.MDcontrol = 1'b1;
        push_exp(op, a, b);
        @(posedge clock); #1;
        md.MDcontrol = 1'b0;
        md.A = $urandom;
        md.B = $urandom;
        md.MDop = ~op;
    endtask

    task automatic wait_result(input int exp_lat, input bit inject);
        int   n;
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (n = 1; n <= 40; n++) begin
            if (inject && (n == 5 || n == 20)) begin
                md.MDcontrol = 1'b1; md.MDop = 1'b0;
                md.A = 32'h0000_1234; md.B = 32'h0000_0055;
            end
            @(posedge clock); #1;
            md.MDcontrol = 1'b0;
            if (n == 1 && exp_lat > 1) chk("busy_run", md.busy, 1);
            if (md.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("timeout", 0, 1);
            if (sbq.size() > 0) void'(sbq.pop_front());
            return;
        end
        e = sbq.pop_front();
        chk("latency", n, exp_lat);
        chk("hi", md.HI, e.hi);
        chk("lo", md.LO, e.lo);
        chk("div0", md.Div0, e.div0);
        chk("busy_done", md.busy, 0);
        @(posedge clock); #1;
        chk("done_pulse", md.done, 0);
        chk("div0_pulse", md.Div0, 0);
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            if (md.done) cnt++;
        end
    endtask

    initial begin
        int cnt;
        logic          rop;
        logic [W-1:0]  ra, rb;
        md.MDcontrol = 1'b0; md.MDop = 1'b0; md.A = '0; md.B = '0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_hi", md.HI, 0);
        chk("rst_lo", md.LO, 0);
        chk("rst_done", md.done, 0);
        chk("rst_busy", md.busy, 0);
        chk("rst_div0", md.Div0, 0);
        @(negedge clock) reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        #1;
        chk("idle_rst_busy", md.busy, 0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;

        start(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_result(33, 1'b0);
        chk("tp_mul_hi", md.HI, 32'hFFFF_FFFF);
        chk("tp_mul_lo", md.LO, 32'hFFFF_FFEB);

        start(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_result(33, 1'b0);
        start(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_result(33, 1'b0);
        chk("tp_minmin_hi", md.HI, 32'h4000_0000);

        start(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_result(33, 1'b0);
        start(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_result(33, 1'b0);
        start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result(33, 1'b0);
        chk("tp_ovf_lo", md.LO, 32'h8000_0000);
        chk("tp_ovf_hi", md.HI, 32'h0);

        start(1'b0, 32'h1234_5678, 32'h0000_0100);
        wait_result(33, 1'b0);
        start(1'b1, 32'd5, 32'd0);
        wait_result(1, 1'b0);
        chk("tp_div0_hi", md.HI, 32'h0000_0012);
        chk("tp_div0_lo", md.LO, 32'h3456_7800);

        start(1'b0, 32'h0001_2345, 32'hFFFF_0003);
        wait_result(33, 1'b1);
        count_done(40, cnt);
        chk("extra_done", cnt, 0);

        start(1'b1, 32'd1000, 32'd7);
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_hi", md.HI, 0);
        chk("abort_lo", md.LO, 0);
        chk("abort_busy", md.busy, 0);
        chk("abort_done", md.done, 0);
        void'(sbq.pop_front());
        m_hi = '0;
        m_lo = '0;
        @(negedge clock) reset = 1'b1;
        count_done(40, cnt);
        chk("abort_no_done", cnt, 0);
        start(1'b1, 32'd1000, 32'hFFFF_FFF9);
        wait_result(33, 1'b0);

        for (int i = 0; i < 8; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = (i == 3) ? 32'h0 : $urandom;
            if (i == 5) rb = 32'h0000_0001;
            start(rop, ra, rb);
            wait_result((rop && rb == '0) ? 1 : 33, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
